// File: rtl/sweep_pattern_gen_pkg.sv
// Shared types, mode encodings and maximal-length LFSR tap masks for the sweep generator.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_e;

  localparam logic MODE_ORD  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  // Right-shift Galois masks (bit k set = tap k+1); each gives period 2^w-1.
  function automatic logic [31:0] lfsr_taps(input int unsigned tot_w);
    logic [31:0] t;
    case (tot_w)
      2:       t = 32'h0000_0003;
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      32:      t = 32'h8020_0003;
      default: t = 32'h0000_0003;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sweep_pattern_gen_if.sv
// Valid/ready pattern bus between the sweep generator and its consumer.
interface sweep_pattern_gen_if #(
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned WIDTH  = 4
);
  localparam int unsigned TOT_W = NUM_IN * WIDTH;

  logic             pat_valid;
  logic             pat_ready;
  logic [TOT_W-1:0] pat_data;
  logic [TOT_W:0]   pat_idx;

  modport master (output pat_valid, output pat_data, output pat_idx, input  pat_ready);
  modport slave  (input  pat_valid, input  pat_data, input  pat_idx, output pat_ready);
endinterface

// File: rtl/sweep_pattern_gen_lfsr.sv
// TOT_W-bit right-shift Galois LFSR; load takes priority over step.
module sweep_lfsr
  import sweep_pkg::*;
#(
  parameter int unsigned TOT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [TOT_W-1:0] seed,
  output logic [TOT_W-1:0] q
);
  localparam logic [TOT_W-1:0] TAPS = TOT_W'(lfsr_taps(TOT_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= (q >> 1) ^ (q[0] ? TAPS : '0);
    end
  end
endmodule

// File: rtl/sweep_pattern_gen.sv
// Exhaustive operand sweep source: ordered odometer (last channel fastest) or LFSR order.
// Channel c sits at pat_data[c*WIDTH +: WIDTH]; in ordered mode the odometer word is channel-reversed onto the bus.
module sweep_pattern_gen
  import sweep_pkg::*;
#(
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned WIDTH  = 4,
  parameter logic [31:0] SEED   = 32'd1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       mode,
  sweep_pattern_gen_if.master        pat,
  output logic                       busy,
  output logic                       done
);
  localparam int unsigned TOT_W = NUM_IN * WIDTH;
  localparam int unsigned IDX_W = TOT_W + 1;
  localparam logic [TOT_W-1:0] SEED_T   = TOT_W'(SEED);
  localparam logic [TOT_W-1:0] SEED_M   = (SEED_T == '0) ? TOT_W'(1) : SEED_T;
  localparam logic [IDX_W-1:0] LAST_IDX = {1'b0, {TOT_W{1'b1}}};

  sweep_state_e     state_q, state_d;
  logic [TOT_W-1:0] data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mode_q, mode_d;
  logic             valid_q, busy_q, done_q;
  logic             lfsr_load_c, lfsr_step_c;
  logic [TOT_W-1:0] lfsr_q;
  logic [TOT_W-1:0] ord_next_c;
  logic             accept_c;

  // Bus channel c <-> odometer digit NUM_IN-1-c; an involution.
  function automatic logic [TOT_W-1:0] chan_swap(input logic [TOT_W-1:0] v);
    logic [TOT_W-1:0] r;
    r = '0;
    for (int unsigned c = 0; c < NUM_IN; c++) begin
      r[c*WIDTH +: WIDTH] = v[(NUM_IN-1-c)*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  sweep_lfsr #(.TOT_W(TOT_W)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load_c),
    .step  (lfsr_step_c),
    .seed  (SEED_M),
    .q     (lfsr_q)
  );

  assign accept_c   = valid_q & pat.pat_ready;
  assign ord_next_c = chan_swap(chan_swap(data_q) + TOT_W'(1));

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    lfsr_load_c = 1'b0;
    lfsr_step_c = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d     = RUN;
          data_d      = '0;
          idx_d       = '0;
          mode_d      = mode;
          lfsr_load_c = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept_c) begin
          idx_d = idx_q + IDX_W'(1);
          if (mode_q == MODE_LFSR) begin
            data_d      = lfsr_q;
            lfsr_step_c = 1'b1;
          end else begin
            data_d = ord_next_c;
          end
          if (idx_q == LAST_IDX) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      mode_q  <= MODE_ORD;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      valid_q <= (state_d == RUN);
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign pat.pat_valid = valid_q;
  assign pat.pat_data  = data_q;
  assign pat.pat_idx   = idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule
